// File: rtl/multizone_irrigation_controller_if.sv
// Sensor/valve bundle between the irrigation controller and its neighbours.
// The master side drives sensors and ticks; the slave side is the controller.
interface multizone_irrigation_controller_if #(
    parameter int ZONES  = 4,
    parameter int TIME_W = 8
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

    logic              tick_i;
    logic              high_level_indicator_i;
    logic              middle_level_indicator_i;
    logic              low_level_indicator_i;
    logic              temperature_i;
    logic              air_humidity_i;
    logic [ZONES-1:0]  soil_dry_i;
    logic [ZONES-1:0]  zone_enable_i;

    logic              error_indicator_o;
    logic              alarm_state_o;
    logic              inlet_valve_o;
    logic [ZONES-1:0]  zone_valve_o;
    logic              sprinkler_o;
    logic              drip_o;
    logic [ZW-1:0]     active_zone_o;
    logic [TIME_W-1:0] remaining_o;
    logic              busy_o;
    logic [ZONES-1:0]  zone_fault_o;

    modport master (
        output tick_i, high_level_indicator_i, middle_level_indicator_i,
               low_level_indicator_i, temperature_i, air_humidity_i,
               soil_dry_i, zone_enable_i,
        input  error_indicator_o, alarm_state_o, inlet_valve_o, zone_valve_o,
               sprinkler_o, drip_o, active_zone_o, remaining_o, busy_o,
               zone_fault_o
    );

    modport slave (
        input  tick_i, high_level_indicator_i, middle_level_indicator_i,
               low_level_indicator_i, temperature_i, air_humidity_i,
               soil_dry_i, zone_enable_i,
        output error_indicator_o, alarm_state_o, inlet_valve_o, zone_valve_o,
               sprinkler_o, drip_o, active_zone_o, remaining_o, busy_o,
               zone_fault_o
    );
endinterface

// File: rtl/multizone_irrigation_controller.sv
// Multizone irrigation controller: registered tank status and a round-robin zone scheduler.
// Define IRRIGATION_WATCHDOG_EN to build the per-zone consecutive-full-run lockout.

`ifdef IRRIGATION_WATCHDOG_EN
// Locks a zone out after its third consecutive full-length run.
module irrigation_zone_wdog (
    input  logic clk,
    input  logic rst_n,
    input  logic full_run,
    input  logic early_stop,
    output logic fault
);
    logic [1:0] runs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runs_q <= '0;
            fault  <= 1'b0;
        end else if (early_stop) begin
            runs_q <= '0;
        end else if (full_run) begin
            if (runs_q == 2'd2) fault <= 1'b1;
            else                runs_q <= runs_q + 2'd1;
        end
    end
endmodule
`endif

module multizone_irrigation_controller #(
    parameter int ZONES          = 4,
    parameter int TIME_W         = 8,
    parameter int SPRINKLER_TIME = 30,
    parameter int DRIP_TIME      = 60,
    parameter int SETTLE_TIME    = 5
) (
    input  logic clk,
    input  logic rst_n,
    multizone_irrigation_controller_if.slave bus
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam logic [ZW:0]        ZN         = (ZW+1)'(ZONES);
    localparam logic [ZONES-1:0]   ZONE0      = ZONES'(1);
    localparam logic [TIME_W-1:0]  SPRK_CNT   = TIME_W'(SPRINKLER_TIME);
    localparam logic [TIME_W-1:0]  DRIP_CNT   = TIME_W'(DRIP_TIME);
    localparam logic [TIME_W-1:0]  SETTLE_CNT = TIME_W'(SETTLE_TIME);
    localparam logic [TIME_W-1:0]  ONE_CNT    = TIME_W'(1);

    typedef enum logic [2:0] {IDLE, SELECT, WATER, SETTLE, FAULT} state_t;

    state_t              state_q, state_d;
    logic [ZW-1:0]       zone_q, zone_d, ptr_q, ptr_d, pick_idx, ptr_wrap;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic                drip_q, drip_d;
    logic                error_q, alarm_q, inlet_q;
    logic                err_now, want_drip, last_tick;
    logic                early_stop, full_run, pick_found;
    logic                in_water, in_settle;
    logic [ZONES-1:0]    req, fault_q, rot;
    logic [2*ZONES-1:0]  req2;
    logic [ZW:0]         sum;

    // Tank status: combinational rules, one register stage.
    assign err_now = (bus.high_level_indicator_i & ~bus.middle_level_indicator_i)
                   | (bus.middle_level_indicator_i & ~bus.low_level_indicator_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
            alarm_q <= 1'b0;
            inlet_q <= 1'b0;
        end else begin
            error_q <= err_now;
            alarm_q <= ~bus.low_level_indicator_i | err_now;
            inlet_q <= ~bus.high_level_indicator_i & ~err_now;
        end
    end

    assign req       = bus.soil_dry_i & bus.zone_enable_i & ~fault_q;
    assign want_drip = bus.temperature_i | ~bus.air_humidity_i | ~bus.middle_level_indicator_i;
    assign last_tick = bus.tick_i & (cnt_q == ONE_CNT);
    assign ptr_wrap  = (zone_q == ZW'(ZONES-1)) ? '0 : zone_q + 1'b1;

    // Rotate req so bit 0 is next_ptr; the lowest set bit is the winner.
    always_comb begin
        req2       = {req, req} >> ptr_q;
        rot        = req2[ZONES-1:0];
        pick_found = |rot;
        pick_idx   = '0;
        sum        = '0;
        for (int i = ZONES-1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr_q} + (ZW+1)'(i);
                if (sum >= ZN) sum = sum - ZN;
                pick_idx = sum[ZW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        zone_d     = zone_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        drip_d     = drip_q;
        early_stop = 1'b0;
        full_run   = 1'b0;
        if (alarm_q) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: if (|req) state_d = SELECT;
                SELECT: begin
                    if (pick_found) begin
                        state_d = WATER;
                        zone_d  = pick_idx;
                        drip_d  = want_drip;
                        cnt_d   = want_drip ? DRIP_CNT : SPRK_CNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WATER: begin
                    // A dropped request outranks the final tick of the same cycle.
                    early_stop = ~req[zone_q];
                    full_run   = ~early_stop & last_tick;
                    if (early_stop | full_run) begin
                        ptr_d   = ptr_wrap;
                        cnt_d   = SETTLE_CNT;
                        state_d = (SETTLE_TIME == 0) ? IDLE : SETTLE;
                    end else if (bus.tick_i) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (last_tick || cnt_q == '0) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (bus.tick_i) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FAULT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            zone_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            drip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zone_q  <= zone_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            drip_q  <= drip_d;
        end
    end

`ifdef IRRIGATION_WATCHDOG_EN
    for (genvar z = 0; z < ZONES; z++) begin : g_wdog
        irrigation_zone_wdog u_wdog (
            .clk        (clk),
            .rst_n      (rst_n),
            .full_run   (full_run   & (zone_q == ZW'(z))),
            .early_stop (early_stop & (zone_q == ZW'(z))),
            .fault      (fault_q[z])
        );
    end
`else
    assign fault_q = '0;
`endif

    // Outputs decode flops only; active zone and remaining read 0 outside a run.
    assign in_water  = (state_q == WATER);
    assign in_settle = (state_q == SETTLE);

    assign bus.error_indicator_o = error_q;
    assign bus.alarm_state_o     = alarm_q;
    assign bus.inlet_valve_o     = inlet_q;
    assign bus.zone_valve_o      = in_water ? (ZONE0 << zone_q) : '0;
    assign bus.sprinkler_o       = in_water & ~drip_q;
    assign bus.drip_o            = in_water & drip_q;
    assign bus.active_zone_o     = in_water ? zone_q : '0;
    assign bus.remaining_o       = (in_water | in_settle) ? cnt_q : '0;
    assign bus.busy_o            = in_water | in_settle;
    assign bus.zone_fault_o      = fault_q;
endmodule
